// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer: per-entry status flags,
// retire FSM states and default geometry.
package rob_pkg;

    localparam int ROB_DEPTH_DEFAULT  = 8;
    localparam int ROB_ARCH_W_DEFAULT = 5;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_t;

    // Control half of an entry; pc/arch/wr live in a plain storage array.
    typedef struct packed {
        logic valid;
        logic done;
        logic exc;
    } rob_flags_t;

endpackage

// File: rtl/rob_ptr.sv
// Circular-buffer pointer with wrap bit (increment / clear) plus one
// comparison against the peer pointer: empty-style equality or full-style.
module rob_ptr #(
    parameter int IDX_W    = 3,
    parameter bit CMP_FULL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [IDX_W:0]   peer,
    output logic [IDX_W:0]   ptr,
    output logic             match
);

    logic [IDX_W:0] ptr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + 1'b1;
        end
    end

    assign ptr = ptr_reg;

    generate
        if (CMP_FULL) begin : g_full
            // Same slot, opposite lap: every entry is occupied.
            assign match = (ptr_reg[IDX_W-1:0] == peer[IDX_W-1:0]) &&
                           (ptr_reg[IDX_W] != peer[IDX_W]);
        end else begin : g_empty
            assign match = (ptr_reg == peer);
        end
    endgenerate

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: program-order allocation, out-of-order
// completion, one retire per cycle from the head, flush on a faulting head.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int  DEPTH  = ROB_DEPTH_DEFAULT,
    parameter int  ARCH_W = ROB_ARCH_W_DEFAULT,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [31:0]       alloc_pc,
    input  logic [ARCH_W-1:0] alloc_arch,
    input  logic              alloc_wr,
    output logic [IDX_W-1:0]  alloc_tag,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_tag,
    input  logic              cmpl_exc,
    output logic              rob_commit_valid,
    output logic [ARCH_W-1:0] rob_commit_arch,
    output logic              exception_occurred,
    output logic [31:0]       exception_pc,
    output logic [IDX_W:0]    count
);

    localparam int PAY_W = 32 + ARCH_W + 1;

    rob_state_t        state_reg;
    rob_flags_t        flags_reg [DEPTH];
    logic [PAY_W-1:0]  payload_mem [DEPTH];

    logic [IDX_W:0]    head_ptr;
    logic [IDX_W:0]    tail_ptr;
    logic              empty;
    logic              full;

    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;
    rob_flags_t        head_flags;
    logic [31:0]       head_pc;
    logic [ARCH_W-1:0] head_arch;
    logic              head_wr;

    logic              alloc_fire;
    logic              cmpl_fire;
    logic              head_ready;
    logic              retire;
    logic              fault;

    logic              commit_valid_reg;
    logic [ARCH_W-1:0] commit_arch_reg;
    logic              exc_occurred_reg;
    logic [31:0]       exc_pc_reg;

    rob_ptr #(.IDX_W(IDX_W), .CMP_FULL(1'b0)) u_head_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (retire),
        .clr     (fault),
        .peer    (tail_ptr),
        .ptr     (head_ptr),
        .match   (empty)
    );

    rob_ptr #(.IDX_W(IDX_W), .CMP_FULL(1'b1)) u_tail_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (alloc_fire),
        .clr     (fault),
        .peer    (head_ptr),
        .ptr     (tail_ptr),
        .match   (full)
    );

    assign head_idx   = head_ptr[IDX_W-1:0];
    assign tail_idx   = tail_ptr[IDX_W-1:0];
    assign head_flags = flags_reg[head_idx];
    assign {head_pc, head_arch, head_wr} = payload_mem[head_idx];

    always_comb begin
        alloc_ready = (state_reg == RUN) && !full;
        alloc_fire  = alloc_valid && alloc_ready;
        cmpl_fire   = (state_reg == RUN) && cmpl_valid && flags_reg[cmpl_tag].valid;
        head_ready  = (state_reg == RUN) && !empty && head_flags.valid && head_flags.done;
        retire      = head_ready && !head_flags.exc;
        fault       = head_ready && head_flags.exc;
    end

    assign alloc_tag = tail_idx;
    assign count     = tail_ptr - head_ptr;

    // Per-entry status; a fault wins over any allocate/complete on the same edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    flags_reg[gi] <= '0;
                end else if (fault) begin
                    flags_reg[gi] <= '0;
                end else begin
                    if (alloc_fire && (tail_idx == IDX_W'(gi))) begin
                        flags_reg[gi] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0};
                    end else if (cmpl_fire && (cmpl_tag == IDX_W'(gi))) begin
                        flags_reg[gi].done <= 1'b1;
                        flags_reg[gi].exc  <= cmpl_exc;
                    end
                    if (retire && (head_idx == IDX_W'(gi))) begin
                        flags_reg[gi].valid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            payload_mem[tail_idx] <= {alloc_pc, alloc_arch, alloc_wr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= RUN;
            commit_valid_reg <= 1'b0;
            commit_arch_reg  <= '0;
            exc_occurred_reg <= 1'b0;
            exc_pc_reg       <= '0;
        end else begin
            commit_valid_reg <= retire;
            commit_arch_reg  <= (retire && head_wr) ? head_arch : '0;
            exc_occurred_reg <= fault;
            case (state_reg)
                RUN: begin
                    if (fault) begin
                        exc_pc_reg <= head_pc;
                        state_reg  <= FLUSH;
                    end
                end
                FLUSH:   state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    assign rob_commit_valid   = commit_valid_reg;
    assign rob_commit_arch    = commit_arch_reg;
    assign exception_occurred = exc_occurred_reg;
    assign exception_pc       = exc_pc_reg;

endmodule
